// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared FSM encoding, forward-select codes and register-index width.
package hazard_ctrl_unit_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// fwd_select: picks the EX operand source for one register from the MEM/WB shadows.
module fwd_select
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int W = REG_ADDR_W
) (
  input  logic [W-1:0] i_rs,
  input  logic [W-1:0] i_rd_m,
  input  logic         i_rw_m,
  input  logic         i_mr_m,
  input  logic [W-1:0] i_rd_w,
  input  logic         i_rw_w,
  output logic [1:0]   o_sel
);
  logic w_hit_m;
  logic w_hit_w;
  // a load sitting in MEM has no data yet, so it is never a forwarding source
  assign w_hit_m = i_rw_m & !i_mr_m & (|i_rd_m) & (i_rd_m == i_rs);
  assign w_hit_w = i_rw_w & (|i_rd_w) & (i_rd_w == i_rs);
  always_comb o_sel = w_hit_m ? FWD_MEM : w_hit_w ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: RV32I load-use stall, branch flush and EX forwarding control.
// Optional performance counters StallCnt/FlushCnt are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::state_e;
  import hazard_ctrl_unit_pkg::RUN;
  import hazard_ctrl_unit_pkg::STALL;
#(
  parameter int REG_ADDR_W       = hazard_ctrl_unit_pkg::REG_ADDR_W,
  parameter int LOAD_USE_BUBBLES = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W            = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  UseRs1D,
  input  logic                  UseRs2D,
  input  logic                  RegWriteD,
  input  logic                  MemReadD,
  input  logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
`endif
);
  state_e                  r_state;
  state_e                  w_state_nx;
  logic [1:0]              r_cnt;
  logic [1:0]              w_cnt_nx;
  logic [REG_ADDR_W-1:0]   r_rs1_e, r_rs2_e, r_rd_e, r_rd_m, r_rd_w;
  logic                    r_rw_e, r_mr_e, r_rw_m, r_mr_m, r_rw_w;
  logic                    w_luse;
  logic                    w_stall;

  assign w_luse = r_mr_e & (|r_rd_e) &
                  ((UseRs1D & (Rs1D == r_rd_e)) | (UseRs2D & (Rs2D == r_rd_e)));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end

  // the RUN cycle that detects the hazard is the first bubble; STALL covers the rest
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (PCSrcE) begin
      w_state_nx = RUN;
      w_cnt_nx   = '0;
    end else if (r_state == RUN) begin
      if (w_luse && LOAD_USE_BUBBLES > 1) begin
        w_state_nx = STALL;
        w_cnt_nx   = 2'(LOAD_USE_BUBBLES - 1);
      end
    end else begin
      w_cnt_nx   = r_cnt - 2'd1;
      w_state_nx = (w_cnt_nx == 2'd0) ? RUN : STALL;
    end
  end

  always_comb begin
    w_stall = !PCSrcE & ((r_state == STALL) | w_luse);
    StallF  = w_stall;
    StallD  = w_stall;
    FlushD  = PCSrcE;
    FlushE  = PCSrcE | w_stall;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {r_rs1_e, r_rs2_e, r_rd_e, r_rw_e, r_mr_e} <= '0;
      {r_rd_m, r_rw_m, r_mr_m}                   <= '0;
      {r_rd_w, r_rw_w}                           <= '0;
    end else begin
      {r_rs1_e, r_rs2_e, r_rd_e, r_rw_e, r_mr_e} <= FlushE ? '0 :
                                                   {Rs1D, Rs2D, RdD, RegWriteD, MemReadD};
      {r_rd_m, r_rw_m, r_mr_m}                   <= {r_rd_e, r_rw_e, r_mr_e};
      {r_rd_w, r_rw_w}                           <= {r_rd_m, r_rw_m};
    end

  fwd_select #(.W(REG_ADDR_W)) u_fwd_a (
    .i_rs(r_rs1_e), .i_rd_m(r_rd_m), .i_rw_m(r_rw_m), .i_mr_m(r_mr_m),
    .i_rd_w(r_rd_w), .i_rw_w(r_rw_w), .o_sel(ForwardAE)
  );

  fwd_select #(.W(REG_ADDR_W)) u_fwd_b (
    .i_rs(r_rs2_e), .i_rd_m(r_rd_m), .i_rw_m(r_rw_m), .i_mr_m(r_mr_m),
    .i_rd_w(r_rd_w), .i_rw_w(r_rw_w), .o_sel(ForwardBE)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(StallD);
      r_flush_cnt <= r_flush_cnt + CNT_W'(PCSrcE);
    end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed checks of stall/flush/forwarding with 1- and 3-bubble instances.
module tb_hazard_ctrl_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       UseRs1D, UseRs2D, RegWriteD, MemReadD, PCSrcE;
  logic       sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic [7:0] o1, o3;
  int         errors = 0;
  int         checks = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  always #5 clk = ~clk;

  assign o1 = {sf1, sd1, fd1, fe1, fa1, fb1};
  assign o3 = {sf3, sd3, fd3, fe3, fa3, fb3};

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1)) u1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
    .PCSrcE(PCSrcE), .StallF(sf1), .StallD(sd1), .FlushD(fd1), .FlushE(fe1),
    .ForwardAE(fa1), .ForwardBE(fb1)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(sc1), .FlushCnt(fc1)
`endif
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(3)) u3 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
    .PCSrcE(PCSrcE), .StallF(sf3), .StallD(sd3), .FlushD(fd3), .FlushE(fe3),
    .ForwardAE(fa3), .ForwardBE(fb3)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(sc3), .FlushCnt(fc3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic d(input int rs1, input int rs2, input int rd,
                   input bit u1_, input bit u2_, input bit rw, input bit mr);
    Rs1D = 5'(rs1); Rs2D = 5'(rs2); RdD = 5'(rd);
    UseRs1D = u1_; UseRs2D = u2_; RegWriteD = rw; MemReadD = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rstp();
    PCSrcE = 1'b0;
    d(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    PCSrcE = 1'b0;
    d(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_u1", o1, 0);
    chk("rst_u3", o3, 0);
    reset = 1'b1;
    tick();
    // load-use: lw x5 then add x6,x5,x1
    d(0, 0, 5, 0, 0, 1, 1); #1; chk("lu_lw", o1, 0); tick();
    d(5, 1, 6, 1, 1, 1, 0); #1; chk("lu1_a", o1, 8'hD0); chk("lu3_a", o3, 8'hD0); tick();
    #1; chk("lu1_b", o1, 8'h00); chk("lu3_b", o3, 8'hD0); tick();
    #1; chk("lu1_c_fwdwb", o1, 8'h04); chk("lu3_c", o3, 8'hD0); tick();
    #1; chk("lu1_d", o1, 8'h00); chk("lu3_run", o3, 8'h00); tick();
    // forwarding: add x7 ; sub x8,x7,x7
    rstp();
    d(1, 2, 7, 1, 1, 1, 0); #1; chk("fw_c0", o1, 0); tick();
    d(7, 7, 8, 1, 1, 1, 0); #1; chk("fw_c1", o1, 0); tick();
    d(0, 0, 0, 0, 0, 0, 0); #1; chk("fw_mem", o1, 8'h0A); tick();
    d(1, 2, 7, 1, 1, 1, 0); tick();
    d(1, 2, 9, 1, 1, 1, 0); tick();
    d(7, 7, 8, 1, 1, 1, 0); #1; chk("fw_c5", o1, 0); tick();
    d(0, 0, 0, 0, 0, 0, 0); #1; chk("fw_wb_u1", o1, 8'h05); chk("fw_wb_u3", o3, 8'h05); tick();
    d(1, 2, 7, 1, 1, 1, 0); tick();
    d(1, 2, 7, 1, 1, 1, 0); tick();
    d(7, 7, 8, 1, 1, 1, 0); tick();
    d(0, 0, 0, 0, 0, 0, 0); #1; chk("fw_mem_prio", o1, 8'h0A); tick();
    // x0 is never a hazard nor forwarded
    rstp();
    d(0, 0, 0, 0, 0, 1, 1); tick();
    d(0, 0, 3, 1, 1, 1, 0); #1; chk("x0_noluse", o1, 0); tick();
    d(1, 2, 0, 1, 1, 1, 0); tick();
    d(0, 0, 3, 1, 1, 1, 0); tick();
    d(0, 0, 0, 0, 0, 0, 0); #1; chk("x0_nofwd_m", o1, 0); tick();
    #1; chk("x0_nofwd_w", o1, 0); tick();
    // branch flush in 2nd cycle of 3-bubble stall
    rstp();
    d(0, 0, 5, 0, 0, 1, 1); tick();
    d(5, 1, 6, 1, 1, 1, 0); #1; chk("fl_stall", o3, 8'hD0); tick();
    PCSrcE = 1'b1; #1; chk("fl_u3", o3, 8'h30); chk("fl_u1", o1, 8'h30); tick();
    PCSrcE = 1'b0; d(0, 0, 0, 0, 0, 0, 0); #1; chk("fl_run", o3, 0); tick();
    #1; chk("fl_nostall", o3, 0); tick();
    // asynchronous reset mid-stall
    rstp();
    d(0, 0, 5, 0, 0, 1, 1); tick();
    d(5, 1, 6, 1, 1, 1, 0); tick();
    #1; chk("ar_stall", o3, 8'hD0);
    reset = 1'b0; #1; chk("ar_u3", o3, 0); chk("ar_u1", o1, 0);
    reset = 1'b1; #1; chk("ar_after", o3, 0); tick();
`ifdef HAZARD_PERF_CNT_EN
    rstp();
    for (int i = 0; i < 4; i++) begin
      d(0, 0, 5, 0, 0, 1, 1); tick();
      d(5, 1, 6, 1, 1, 1, 0); tick();
      tick();
    end
    d(0, 0, 0, 0, 0, 0, 0);
    PCSrcE = 1'b1; tick(); tick();
    PCSrcE = 1'b0; #1;
    chk("perf_stall", sc1, 32'd4);
    chk("perf_flush", fc1, 32'd2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
